// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory bus between the fetch stage and instruction memory
//
// Purpose: carries the fetch address out to instruction memory and the
//          combinationally read instruction word back.
// Signals:
//    imem_addr   32  fetch address (driven by the fetch stage)
//    imem_rdata  32  instruction word read from imem_addr
// Modports:
//    master  fetch stage side (drives imem_addr)
//    slave   memory side (drives imem_rdata)
interface if_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, next-PC select, optional BTB
//
// Purpose: owns the program counter, drives the instruction-memory address and
//          presents instruction, PC and PC+4 to IF/ID. Holds on stall, restarts
//          on EX redirect (raising control_hazard). Optional macro BTB_EN builds
//          a direct-mapped branch target buffer with 2-bit counters.
// Parameters:
//    RESET_PC     PC loaded on reset
//    BTB_ENTRIES  BTB depth (power of two, 2..16), used only with BTB_EN
// Ports:
//    clk, rst                          clock, asynchronous active-high reset
//    pipeline_stop                     hold PC
//    ex_redirect_valid/_pc             restart fetch at ex_redirect_pc
//    ex_br_valid/_pc/_taken/_target    resolved branch, trains the BTB
//    imem                              instruction-memory bus (master)
//    if_pc, if_pc4, if_inst            fetch results toward IF/ID
//    if_pred_taken, if_pred_target     BTB prediction for the current PC
//    control_hazard                    flush request to IF/ID
module if_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipeline_stop,
   input  logic              ex_redirect_valid,
   input  logic [31:0]       ex_redirect_pc,
   input  logic              ex_br_valid,
   input  logic [31:0]       ex_br_pc,
   input  logic              ex_br_taken,
   input  logic [31:0]       ex_br_target,
   if_stage_if.master        imem,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_pc4,
   output logic [31:0]       if_inst,
   output logic              if_pred_taken,
   output logic [31:0]       if_pred_target,
   output logic              control_hazard
);

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pred_taken;
   logic [31:0] pred_target;

`ifdef BTB_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [31:0]      btb_target [BTB_ENTRIES];
   logic [1:0]       btb_ctr    [BTB_ENTRIES];

   logic [IDX_W-1:0] look_idx;
   logic [TAG_W-1:0] look_tag;
   logic             look_hit;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             unused_br;

   assign look_idx  = pc[IDX_W+1:2];
   assign look_tag  = pc[31:IDX_W+2];
   assign upd_idx   = ex_br_pc[IDX_W+1:2];
   assign upd_tag   = ex_br_pc[31:IDX_W+2];
   // Instruction alignment bits carry no index/tag information.
   assign unused_br = ^ex_br_pc[1:0];

   // Lookup reads the array before this edge's update, so a same-cycle
   // update at the same index is not visible until the next cycle.
   assign look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
   assign pred_taken  = look_hit && btb_ctr[look_idx][1];
   assign pred_target = pred_taken ? btb_target[look_idx] : 32'h0;
   assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= 32'h0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (ex_br_valid) begin
         if (upd_hit) begin
            if (ex_br_taken) begin
               if (btb_ctr[upd_idx] != 2'b11)
                  btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
               btb_target[upd_idx] <= ex_br_target;
            end else if (btb_ctr[upd_idx] != 2'b00) begin
               btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
            end
         end else if (ex_br_taken) begin
            // Allocate (or evict the aliasing entry) weakly taken.
            btb_valid[upd_idx]  <= 1'b1;
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= ex_br_target;
            btb_ctr[upd_idx]    <= 2'b10;
         end
      end
   end
`else
   logic unused_br;

   assign pred_taken  = 1'b0;
   assign pred_target = 32'h0;
   // Training inputs and BTB depth have no use without the BTB.
   assign unused_br   = ^{ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target, 32'(BTB_ENTRIES)};
`endif

   // Redirect beats stall: the stalled instruction in ID is wrong-path anyway.
   always_comb begin
      pc_next = pc + 32'd4;
      if (ex_redirect_valid)
         pc_next = ex_redirect_pc;
      else if (pipeline_stop)
         pc_next = pc;
      else if (pred_taken)
         pc_next = pred_target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

   assign imem.imem_addr = pc;
   assign if_pc          = pc;
   assign if_pc4         = pc + 32'd4;
   assign if_inst        = imem.imem_rdata;
   assign if_pred_taken  = pred_taken;
   assign if_pred_target = pred_target;
   assign control_hazard = ex_redirect_valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pipeline_stop = 1'b0;
   logic        ex_redirect_valid = 1'b0;
   logic [31:0] ex_redirect_pc = 32'h0;
   logic        ex_br_valid = 1'b0;
   logic [31:0] ex_br_pc = 32'h0;
   logic        ex_br_taken = 1'b0;
   logic [31:0] ex_br_target = 32'h0;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_inst;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        control_hazard;

   int n_checks = 0;
   int n_fail   = 0;

   if_stage_if bus ();

   // Instruction memory model: word is a fixed scramble of its address.
   assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

   if_stage #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .pipeline_stop     (pipeline_stop),
      .ex_redirect_valid (ex_redirect_valid),
      .ex_redirect_pc    (ex_redirect_pc),
      .ex_br_valid       (ex_br_valid),
      .ex_br_pc          (ex_br_pc),
      .ex_br_taken       (ex_br_taken),
      .ex_br_target      (ex_br_target),
      .imem              (bus.master),
      .if_pc             (if_pc),
      .if_pc4            (if_pc4),
      .if_inst           (if_inst),
      .if_pred_taken     (if_pred_taken),
      .if_pred_target    (if_pred_target),
      .control_hazard    (control_hazard)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Full view of the current fetch: PC, PC+4, address and instruction word.
   task automatic check_fetch(input string tag, input logic [31:0] exp_pc);
      check({tag, ".pc"},   if_pc,         exp_pc);
      check({tag, ".pc4"},  if_pc4,        exp_pc + 32'd4);
      check({tag, ".addr"}, bus.imem_addr, exp_pc);
      check({tag, ".inst"}, if_inst,       exp_pc ^ 32'hA5A5_0000);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #1 rst = 1'b1;
      #1;
      check_fetch("reset", 32'h0);
      check("reset.pred_taken",  {31'h0, if_pred_taken}, 32'h0);
      check("reset.pred_target", if_pred_target, 32'h0);
      check("reset.hazard",      {31'h0, control_hazard}, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      check_fetch("free0", 32'h0);
      tick(); check_fetch("free1", 32'h4);
      tick(); check_fetch("free2", 32'h8);
      tick(); check_fetch("free3", 32'hC);
      check("free3.hazard", {31'h0, control_hazard}, 32'h0);
      tick(); check_fetch("pre_stall", 32'h10);

      // Stall for two edges at 0x10, then resume.
      pipeline_stop = 1'b1;
      tick(); check("stall1.pc", if_pc, 32'h10);
      tick(); check("stall2.pc", if_pc, 32'h10);
      pipeline_stop = 1'b0;
      tick(); check("stall_rel.pc", if_pc, 32'h14);

      // Redirect together with stall: redirect wins.
      pipeline_stop     = 1'b1;
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h100;
      #1;
      check("redir.hazard", {31'h0, control_hazard}, 32'h1);
      check("redir.pc_same", if_pc, 32'h14);
      tick();
      pipeline_stop     = 1'b0;
      ex_redirect_valid = 1'b0;
      #1;
      check_fetch("redir.target", 32'h100);
      check("redir.hazard_off", {31'h0, control_hazard}, 32'h0);
      tick(); check("redir.next", if_pc, 32'h104);

      // Wrap-around at the top of the address space.
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'hFFFF_FFFC;
      tick();
      ex_redirect_valid = 1'b0;
      #1;
      check("wrap.pc",  if_pc,  32'hFFFF_FFFC);
      check("wrap.pc4", if_pc4, 32'h0);
      tick(); check("wrap.next", if_pc, 32'h0);

      // Low PC bits pass through untouched.
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h302;
      tick();
      ex_redirect_valid = 1'b0;
      #1;
      check("lowbits.pc", if_pc, 32'h302);
      tick(); check("lowbits.next", if_pc, 32'h306);

      // Reset mid-operation discards a pending redirect, immediately.
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h200;
      #1 rst = 1'b1;
      #1;
      check("midrst.pc_async", if_pc, 32'h0);
      tick();
      check("midrst.pc_held", if_pc, 32'h0);
      rst = 1'b0;
      ex_redirect_valid = 1'b0;
      #1;
      check_fetch("midrst.first", 32'h0);
      tick(); check("midrst.next", if_pc, 32'h4);

`ifdef BTB_EN
      // Same-cycle update and fetch of 0x20: lookup sees pre-update state.
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h20;
      tick();
      ex_redirect_valid = 1'b0;
      ex_br_valid  = 1'b1;
      ex_br_pc     = 32'h20;
      ex_br_taken  = 1'b1;
      ex_br_target = 32'h80;
      #1;
      check("btb_same.pc", if_pc, 32'h20);
      check("btb_same.pred", {31'h0, if_pred_taken}, 32'h0);
      check("btb_same.tgt", if_pred_target, 32'h0);
      tick();
      ex_br_valid = 1'b0;
      #1;
      check("btb_same.next", if_pc, 32'h24);

      // Trained once (counter 10): fetch of 0x20 predicts taken to 0x80.
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h20;
      tick();
      ex_redirect_valid = 1'b0;
      #1;
      check("btb_hit.pred", {31'h0, if_pred_taken}, 32'h1);
      check("btb_hit.tgt",  if_pred_target, 32'h80);
      tick(); check("btb_hit.next", if_pc, 32'h80);
      check("btb_alias.pred", {31'h0, if_pred_taken}, 32'h0);

      // Two not-taken updates: 10 -> 01 -> 00.
      ex_br_valid = 1'b1;
      ex_br_taken = 1'b0;
      tick();
      tick();
      ex_br_valid = 1'b0;
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h20;
      tick();
      ex_redirect_valid = 1'b0;
      #1;
      check("btb_nt.pc", if_pc, 32'h20);
      check("btb_nt.pred", {31'h0, if_pred_taken}, 32'h0);
      tick(); check("btb_nt.next", if_pc, 32'h24);
`else
      // Without the BTB, training inputs never produce a prediction.
      ex_br_valid  = 1'b1;
      ex_br_pc     = 32'h4;
      ex_br_taken  = 1'b1;
      ex_br_target = 32'h80;
      tick();
      ex_redirect_valid = 1'b1;
      ex_redirect_pc    = 32'h4;
      tick();
      ex_redirect_valid = 1'b0;
      ex_br_valid = 1'b0;
      #1;
      check("nobtb.pred", {31'h0, if_pred_taken}, 32'h0);
      check("nobtb.tgt",  if_pred_target, 32'h0);
      tick(); check("nobtb.next", if_pc, 32'h8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
